// File: rtl/dm_result_reader.sv
// Reads a 3-word header (total_i/j/k) from data memory, then streams i*k result
// words through a 2-entry FIFO. Build option RESULT_CHECKSUM_EN appends a 16-bit sum word.
module dm_result_reader #(
  parameter logic [15:0] HDR_BASE = 16'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        dm_rd_en,
  output logic [15:0] dm_addr,
  input  logic [15:0] dm_output_data,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // state    | meaning
  // S_IDLE   | waiting for start
  // S_HDR    | header reads at HDR_BASE..+2, last cycle latches total_k
  // S_CALC   | derive base/count, range check
  // S_STREAM | issue result reads under FIFO credit
  // S_DRAIN  | all reads issued, emptying FIFO (plus checksum word)
  // S_FIN    | done pulse
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_CALC, S_STREAM, S_DRAIN, S_FIN} state_t;

  state_t      state, state_nxt;
  logic [1:0]  hdr_cnt;
  logic [15:0] tot_i, tot_j, tot_k;
  logic [15:0] rd_addr, addr_hold;
  logic [16:0] rd_rem;
  logic        strm_d1;
  logic [31:0] base_c, count_c, end_c;
  logic        calc_err;
  logic        pop, push, push_last, cks_push;
  logic [15:0] push_data;
  logic [1:0]  occ, occ_after_pop, credit_used;
  logic        wr_ptr, rd_ptr;
  logic [15:0] fifo_data [2];
  logic        fifo_last [2];
`ifdef RESULT_CHECKSUM_EN
  logic [15:0] cks_sum;
  logic        cks_done;
`else
  logic        last_d1;
`endif

  assign base_c   = 32'(HDR_BASE) + 32'd3 + 32'(tot_i) * 32'(tot_j) + 32'(tot_j) * 32'(tot_k);
  assign count_c  = 32'(tot_i) * 32'(tot_k);
  assign end_c    = base_c + count_c - 32'd1;
  assign calc_err = (count_c != 32'd0) && (end_c > 32'h0000_FFFF);

  assign out_valid     = (occ != 2'd0);
  assign out_data      = fifo_data[rd_ptr];
  assign out_last      = out_valid & fifo_last[rd_ptr];
  assign pop           = out_valid & out_ready;
  assign occ_after_pop = occ - {1'b0, pop};
  // Word arriving this cycle still needs a FIFO slot, so it counts against the credit.
  assign credit_used   = occ_after_pop + {1'b0, strm_d1};
  assign busy          = (state != S_IDLE) && (state != S_FIN);
  assign done          = (state == S_FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    dm_rd_en  = 1'b0;
    dm_addr   = addr_hold;
    cks_push  = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_HDR;
      S_HDR: begin
        if (hdr_cnt != 2'd3) begin
          dm_rd_en = 1'b1;
          dm_addr  = HDR_BASE + 16'(hdr_cnt);
        end else begin
          state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (calc_err)               state_nxt = S_FIN;
        else if (count_c != 32'd0)  state_nxt = S_STREAM;
`ifdef RESULT_CHECKSUM_EN
        else                        state_nxt = S_DRAIN;
`else
        else                        state_nxt = S_FIN;
`endif
      end
      S_STREAM: begin
        if (credit_used < 2'd2) begin
          dm_rd_en = 1'b1;
          dm_addr  = rd_addr;
          if (rd_rem == 17'd1) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
`ifdef RESULT_CHECKSUM_EN
        if (!cks_done && !strm_d1 && (occ_after_pop < 2'd2)) cks_push = 1'b1;
`endif
        if (pop && out_last) state_nxt = S_FIN;
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_cnt   <= '0;
      tot_i     <= '0;
      tot_j     <= '0;
      tot_k     <= '0;
      rd_addr   <= '0;
      rd_rem    <= '0;
      strm_d1   <= 1'b0;
      addr_hold <= '0;
      err       <= 1'b0;
    end else begin
      strm_d1 <= (state == S_STREAM) && dm_rd_en;
      if (dm_rd_en) addr_hold <= dm_addr;
      case (state)
        S_IDLE: begin
          hdr_cnt <= '0;
          if (start) err <= 1'b0;
        end
        S_HDR: begin
          if (hdr_cnt != 2'd3) hdr_cnt <= hdr_cnt + 2'd1;
          case (hdr_cnt)
            2'd1:    tot_i <= dm_output_data;
            2'd2:    tot_j <= dm_output_data;
            2'd3:    tot_k <= dm_output_data;
            default: ;
          endcase
        end
        S_CALC: begin
          rd_addr <= base_c[15:0];
          rd_rem  <= count_c[16:0];
          if (calc_err) err <= 1'b1;
        end
        S_STREAM: begin
          if (dm_rd_en) begin
            rd_addr <= rd_addr + 16'd1;
            rd_rem  <= rd_rem - 17'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RESULT_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cks_sum  <= '0;
      cks_done <= 1'b0;
    end else if (state == S_IDLE && start) begin
      cks_sum  <= '0;
      cks_done <= 1'b0;
    end else begin
      if (strm_d1)  cks_sum  <= cks_sum + dm_output_data;
      if (cks_push) cks_done <= 1'b1;
    end
  end
  assign push_data = cks_push ? cks_sum : dm_output_data;
  assign push_last = cks_push;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_d1 <= 1'b0;
    else        last_d1 <= (state == S_STREAM) && dm_rd_en && (rd_rem == 17'd1);
  end
  assign push_data = dm_output_data;
  assign push_last = last_d1;
`endif

  assign push = strm_d1 | cks_push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last[0] <= 1'b0;
      fifo_last[1] <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      occ          <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= push_data;
        fifo_last[wr_ptr] <= push_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
